// File: rtl/aes128_fixed_encrypt_serial_if.sv
// aes128_fixed_encrypt_serial_if: ciphertext byte stream from the fixed AES-128 core
interface aes128_fixed_encrypt_serial_if;
    logic [7:0] finalout;
    logic       out_valid;
    logic       done;
    modport master (output finalout, output out_valid, output done);
    modport slave  (input finalout, input out_valid, input done);
endinterface

// File: rtl/aes128_fixed_encrypt_serial.sv
// aes128_fixed_encrypt_serial: one-shot AES-128 encryption of a fixed block, one round per clock,
// then the ciphertext is streamed out byte 0 first.
module aes128_fixed_encrypt_serial #(
    parameter logic [127:0] PLAINTEXT = 128'h00112233445566778899aabbccddeeff,
    parameter logic [127:0] KEY       = 128'h000102030405060708090a0b0c0d0e0f
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    aes128_fixed_encrypt_serial_if.master        bus
);
    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] OUT   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // byte x of the table sits at bits [8*(255-x) +: 8]
    localparam logic [2047:0] SBOX = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    logic [1:0]   st_q, st_d;
    logic [127:0] blk_q, blk_d, key_q, key_d;
    logic [3:0]   rnd_q, rnd_d, idx_q, idx_d;
    logic [7:0]   out_q, out_d;
    logic         vld_q, vld_d, done_q, done_d;

    logic [7:0]   rcon;
    logic [31:0]  rot, tmp;
    logic [127:0] nkey, rnd_out;
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   mc [16];

    assign rcon = rnd_q == 4'd9 ? 8'h1b : rnd_q == 4'd10 ? 8'h36 : 8'h01 << (rnd_q - 4'd1);
    assign rot  = {key_q[23:0], key_q[31:24]};
    assign tmp  = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign nkey[127:96] = key_q[127:96] ^ tmp;
    assign nkey[95:64]  = key_q[95:64] ^ nkey[127:96];
    assign nkey[63:32]  = key_q[63:32] ^ nkey[95:64];
    assign nkey[31:0]   = key_q[31:0] ^ nkey[63:32];

    for (genvar n = 0; n < 16; n++) begin : g_b
        localparam int C = 4 * (n / 4);
        localparam int R = n % 4;
        assign sb[n] = sbox(blk_q[127-8*n -: 8]);
        assign sr[n] = sb[(4 * (n / 4 + R) + R) % 16];
        assign mc[n] = xt(sr[C+R]) ^ xt(sr[C+(R+1)%4]) ^ sr[C+(R+1)%4] ^ sr[C+(R+2)%4] ^ sr[C+(R+3)%4];
        assign rnd_out[127-8*n -: 8] = (rnd_q == 4'd10 ? sr[n] : mc[n]) ^ nkey[127-8*n -: 8];
    end

    always_comb begin
        st_d   = st_q;
        blk_d  = blk_q;
        key_d  = key_q;
        rnd_d  = rnd_q;
        idx_d  = idx_q;
        out_d  = out_q;
        vld_d  = 1'b0;
        done_d = done_q;
        case (st_q)
            LOAD: begin
                blk_d = PLAINTEXT ^ KEY;
                key_d = KEY;
                rnd_d = 4'd1;
                st_d  = ROUND;
            end
            ROUND: begin
                blk_d = rnd_out;
                key_d = nkey;
                rnd_d = rnd_q + 4'd1;
                idx_d = 4'd0;
                st_d  = rnd_q == 4'd10 ? OUT : ROUND;
            end
            OUT: begin
                out_d = blk_q[{~idx_q, 3'b000} +: 8];
                vld_d = 1'b1;
                idx_d = idx_q + 4'd1;
                st_d  = idx_q == 4'd15 ? DONE : OUT;
            end
            default: done_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= LOAD;
            blk_q  <= '0;
            key_q  <= '0;
            rnd_q  <= '0;
            idx_q  <= '0;
            out_q  <= '0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            blk_q  <= blk_d;
            key_q  <= key_d;
            rnd_q  <= rnd_d;
            idx_q  <= idx_d;
            out_q  <= out_d;
            vld_q  <= vld_d;
            done_q <= done_d;
        end
    end

    assign bus.finalout  = out_q;
    assign bus.out_valid = vld_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_aes128_fixed_encrypt_serial.sv
// tb_aes128_fixed_encrypt_serial: directed checks of the default and FIPS-197 example instances
module tb_aes128_fixed_encrypt_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    aes128_fixed_encrypt_serial_if bus_a ();
    aes128_fixed_encrypt_serial_if bus_b ();

    aes128_fixed_encrypt_serial dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    aes128_fixed_encrypt_serial #(
        .PLAINTEXT(128'h3243f6a8885a308d313198a2e0370734),
        .KEY      (128'h2b7e151628aed2a6abf7158809cf4f3c)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    typedef struct {
        int         idx;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " a.finalout"}, 128'(bus_a.finalout), 128'h0);
        chk({nm, " a.out_valid"}, 128'(bus_a.out_valid), 128'h0);
        chk({nm, " a.done"}, 128'(bus_a.done), 128'h0);
        chk({nm, " b.finalout"}, 128'(bus_b.finalout), 128'h0);
        chk({nm, " b.out_valid"}, 128'(bus_b.out_valid), 128'h0);
        chk({nm, " b.done"}, 128'(bus_b.done), 128'h0);
    endtask

    // reset has just been released ahead of edge 1
    task automatic full_run(input bit chk_int);
        for (int e = 1; e <= 28; e++) begin
            @(posedge clk);
            #1;
            if (chk_int && e == 1) chk("state after E1", dut_a.blk_q, 128'h00102030405060708090a0b0c0d0e0f0);
            if (chk_int && e == 11) chk("round10 key", dut_a.key_q, 128'h13111d7fe3944a17f307a78b4d2b30c5);
            if (e <= 11) begin
                chk($sformatf("valid low e%0d a", e), 128'(bus_a.out_valid), 128'h0);
                chk($sformatf("valid low e%0d b", e), 128'(bus_b.out_valid), 128'h0);
            end else if (e <= 27) begin
                chk($sformatf("valid e%0d a", e), 128'(bus_a.out_valid), 128'h1);
                chk($sformatf("valid e%0d b", e), 128'(bus_b.out_valid), 128'h1);
                chk($sformatf("byte %0d a", tbl[e-12].idx), 128'(bus_a.finalout), 128'(tbl[e-12].exp_a));
                chk($sformatf("byte %0d b", tbl[e-12].idx), 128'(bus_b.finalout), 128'(tbl[e-12].exp_b));
                chk($sformatf("done low e%0d a", e), 128'(bus_a.done), 128'h0);
            end else begin
                chk("valid after e28 a", 128'(bus_a.out_valid), 128'h0);
                chk("done e28 a", 128'(bus_a.done), 128'h1);
                chk("done e28 b", 128'(bus_b.done), 128'h1);
                chk("hold byte15 a", 128'(bus_a.finalout), 128'h5a);
            end
        end
    endtask

    initial begin
        logic [127:0] ca;
        logic [127:0] cb;
        ca = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        cb = 128'h3925841d02dc09fbdc118597196a0b32;
        for (int i = 0; i < 16; i++) begin
            tbl[i].idx   = i;
            tbl[i].exp_a = ca[127-8*i -: 8];
            tbl[i].exp_b = cb[127-8*i -: 8];
        end

        repeat (20) begin
            @(negedge clk);
            chk_idle("held reset");
        end

        @(negedge clk);
        rst_n = 1'b1;
        full_run(1'b1);
        repeat (50) begin
            @(negedge clk);
            chk("stay 5a", 128'(bus_a.finalout), 128'h5a);
            chk("stay done", 128'(bus_a.done), 128'h1);
            chk("stay invalid", 128'(bus_a.out_valid), 128'h0);
        end

        // abort during round 5 (edge 6)
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_idle("reset after done");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_idle("abort round5");
        @(negedge clk);
        rst_n = 1'b1;
        full_run(1'b1);

        // abort while byte 7 is on the bus (edge 19)
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (19) @(posedge clk);
        #2;
        chk("byte7 before abort a", 128'(bus_a.finalout), 128'h30);
        chk("byte7 before abort b", 128'(bus_b.finalout), 128'hfb);
        rst_n = 1'b0;
        #1 chk_idle("abort out7");
        @(negedge clk);
        rst_n = 1'b1;
        full_run(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes128_fixed_encrypt_serial.md
Name: aes128_fixed_encrypt_serial

Overview:
- Self-contained AES-128 encryption engine with a built-in plaintext and cipher key, set by parameters.
- After reset release it runs one encryption: one round per clock with on-the-fly key expansion.
- It then streams the 16-byte ciphertext out one byte per clock on an 8-bit bus.
- Used as a standalone FPGA demo/top-level core with only a clock and reset as inputs.

Parameters:
- PLAINTEXT, 128'h00112233445566778899aabbccddeeff, input block; bits [127:120] are byte 0.
- KEY, 128'h000102030405060708090a0b0c0d0e0f, AES-128 cipher key; bits [127:120] are byte 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- finalout  output  8  current ciphertext byte (registered).
- out_valid  output  1  high while finalout carries a new ciphertext byte.
- done  output  1  high once all 16 bytes have been emitted; sticky until reset.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to LOAD.
  - finalout=8'h00, out_valid=0, done=0.
  - State register and round-key register are cleared; round counter=0; byte index=0.
- FSM states: LOAD -> ROUND -> OUT -> DONE. Edges are counted from the first rising edge with rst_n=1.
  - E1 (LOAD): state <= PLAINTEXT ^ KEY; round key <= KEY; round <= 1; go to ROUND.
  - E2..E11 (ROUND, rounds 1..10):
    - Expand the next round key from the current one: RotWord, SubWord, Rcon = 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
    - Apply SubBytes, ShiftRows, MixColumns (omitted in round 10), then AddRoundKey with the new key.
    - After round 10, go to OUT with byte index 0.
  - E12..E27 (OUT): finalout <= ciphertext byte[index] (byte 0 = bits [127:120] first); out_valid <= 1; index++. After index 15, go to DONE.
  - E28 onward (DONE): out_valid <= 0; done <= 1; finalout holds byte 15. No further activity until reset.
- State byte ordering: column-major per FIPS-197, byte n = bits [127-8n -: 8], column c = bytes 4c..4c+3.
- ShiftRows rotates row r left by r positions.
- MixColumns uses xtime over GF(2^8) with polynomial 0x11b.
- S-box: combinational, 16 instances for the state and 4 for the key word. Either a 256-entry table or GF(2^8) inverse plus affine transform is allowed; results must be FIPS-197 exact.
- Round timing:
  - One round per cycle; no pipelining.
  - Total latency from reset release to first valid byte: 12 edges.
  - out_valid stays high for exactly 16 consecutive cycles.
- Reset asserted mid-operation (any state): immediate abort, outputs return to reset values. The encryption restarts from LOAD after release.
- rst_n held low: outputs stay at reset values indefinitely.

Test Plan:
- Default parameters, rst_n low 100 ns then high:
  - finalout sequence while out_valid=1 is 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a.
  - First byte appears after the 12th rising edge.
- Internal check during the same run: round key after round 10 = 13111d7fe3944a17f307a78b4d2b30c5; state after E1 = 00102030405060708090a0b0c0d0e0f0.
- Override PLAINTEXT=3243f6a8885a308d313198a2e0370734, KEY=2b7e151628aed2a6abf7158809cf4f3c -> output bytes 39 25 84 1d 02 dc 09 fb dc 11 85 97 19 6a 0b 32.
- Completion: out_valid high for exactly 16 cycles, then done=1 from edge 28. finalout stays 8'h5a (default vectors) for 50+ further cycles.
- Assert rst_n low during round 5 (and separately during OUT byte 7):
  - finalout=00, out_valid=0 and done=0 immediately, without waiting for a clock edge.
  - After release, the full correct 16-byte sequence is emitted again.
- Hold rst_n low for 20 cycles -> out_valid and done never assert; finalout stays 00.
